// File: rtl/data_bus_master.sv
// data_bus_master: one-at-a-time load/store initiator between MEM stage and byte-lane data RAM.
// Latency: ack_o WAIT_CYCLES+2 cycles after request; misaligned requests (ALIGN_EXC_EN) ack after 1 cycle.
// Backpressure: stallreq_o holds the pipeline from request through ACCESS and drops in DONE.
// Optional macro ALIGN_EXC_EN: misaligned accesses raise adel_o/ades_o instead of being force-aligned.
module data_bus_master #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;

  logic        req_half;
  logic        req_word;
  logic        req_store;
  logic        req_err;
  logic [31:0] req_addr;
  logic        op_store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Classify the incoming request by access size and direction.
  always_comb begin
    req_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    req_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    req_store = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
  end

`ifdef ALIGN_EXC_EN
  // Misaligned halfword/word requests become an error acknowledge with no RAM access.
  assign req_err  = (req_half && addr_i[0]) || (req_word && (addr_i[1:0] != 2'b00));
  assign req_addr = addr_i;
`else
  // Misaligned requests are silently aligned down to the access size.
  assign req_err  = 1'b0;
  assign req_addr = {addr_i[31:2], addr_i[1] & ~req_word, addr_i[0] & ~req_half & ~req_word};
`endif

  assign op_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  // Pick the addressed byte/halfword (big-endian lanes) and extend it per load type.
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_data_i[31:24];
      2'b01:   ld_byte = mem_data_i[23:16];
      2'b10:   ld_byte = mem_data_i[15:8];
      default: ld_byte = mem_data_i[7:0];
    endcase
    ld_half = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h000000, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = mem_data_i;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; req_i is ignored in DONE since it still shows the completing instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = req_err ? DONE : ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM-side outputs decode registered state only, so req_i never reaches the RAM combinationally.
  always_comb begin
    mem_ce_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'h0;
    mem_sel_o  = 4'b0000;
    mem_data_o = 32'h0;
    stallreq_o = (state == ACCESS) || ((state == IDLE) && req_i);
    if (state == ACCESS) begin
      mem_ce_o   = 1'b1;
      mem_we_o   = op_store;
      mem_addr_o = {addr_q[31:2], 2'b00};
      case (op_q)
        OP_LB, OP_LBU, OP_SB: begin
          mem_sel_o  = 4'b1000 >> addr_q[1:0];
          mem_data_o = {4{wdata_q[7:0]}};
        end
        OP_LH, OP_LHU, OP_SH: begin
          mem_sel_o  = addr_q[1] ? 4'b0011 : 4'b1100;
          mem_data_o = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_sel_o  = 4'b1111;
          mem_data_o = wdata_q;
        end
      endcase
    end
  end

  // Request latch, wait counter and registered completion (ack, data, error flags).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_LB;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 4'd0;
      ack_o   <= 1'b0;
      rdata_o <= 32'h0;
      adel_o  <= 1'b0;
      ades_o  <= 1'b0;
    end else begin
      ack_o  <= 1'b0;
      adel_o <= 1'b0;
      ades_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            if (req_err) begin
              ack_o   <= 1'b1;
              rdata_o <= 32'h0;
              adel_o  <= ~req_store;
              ades_o  <= req_store;
            end else begin
              op_q    <= mem_op_i;
              addr_q  <= req_addr;
              wdata_q <= wdata_i;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack_o   <= 1'b1;
            rdata_o <= op_store ? 32'h0 : ld_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_bus_master.md
# data_bus_master

Multi-cycle bus initiator between the MEM pipeline stage and the word-organised, byte-lane data RAM. It accepts one load/store request at a time and drives the RAM's chip-enable, write-enable, address, byte-select and write-data lines. It holds the pipeline with a stall request for the duration of the access, then returns sign- or zero-extended load data with a one-cycle acknowledge. Byte order is big-endian: address offset 0 maps to lane 3, data[31:24].

## Interface
- `WAIT_CYCLES`, default 1: extra RAM access cycles before load data is sampled. Legal range 0–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_i` in 1: MEM stage has a memory instruction.
- `mem_op_i` in 3: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-justified.
- `ack_o` out 1: access complete, registered one-cycle pulse.
- `rdata_o` out 32: extended load data, valid while `ack_o`=1.
- `stallreq_o` out 1: combinational pipeline hold.
- `adel_o` out 1: load address error, coincident with `ack_o`.
- `ades_o` out 1: store address error, coincident with `ack_o`.
- `mem_ce_o` out 1: RAM chip enable.
- `mem_we_o` out 1: RAM write enable.
- `mem_addr_o` out 32: word address, with bits [1:0] always 00.
- `mem_sel_o` out 4: byte-lane select.
- `mem_data_o` out 32: lane-replicated write data.
- `mem_data_i` in 32: RAM read data, combinational from the RAM.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - `req_i`=1 and aligned: latch op, address and data; load the wait counter with `WAIT_CYCLES`; go to ACCESS.
  - Misaligned request (see Configuration): go to DONE with the error flag set and no RAM access.
- **ACCESS**
  - `mem_ce_o`=1 for the whole state.
  - `mem_we_o`=1 for the whole state on stores; repeated writes of the same data are harmless.
  - Counter ≠ 0: decrement and stay in ACCESS.
  - Counter = 0: capture extended `mem_data_i` into `rdata_o` (stores capture 0); set `ack_o`; go to DONE.
- **DONE**
  - `ack_o`=1, `mem_ce_o`=0.
  - `req_i` is ignored, because it still reflects the completing instruction.
  - Next state: IDLE.
- **Byte-lane select**, by offset `addr[1:0]`:
  - Byte: 00→1000, 01→0100, 10→0010, 11→0001.
  - Halfword: 00→1100, 10→0011.
  - Word: 1111.
- **Write data**
  - SB drives `{4{wdata_i[7:0]}}`.
  - SH drives `{2{wdata_i[15:0]}}`.
  - SW drives `wdata_i` unchanged.
- **Load data**: select the addressed byte or halfword, then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.
- **stallreq_o** = (IDLE & `req_i`) | ACCESS. It is 0 in DONE.
- **Reset**
  - Effect: state IDLE, counter 0, every output 0.
  - Reset asserted mid-ACCESS: `mem_ce_o`/`mem_we_o` drop immediately, no `ack_o` is produced, and the aborted request is lost.

## Timing
- Request presented in cycle 0: ACCESS spans cycles 1..`WAIT_CYCLES`+1, and `ack_o` is high in cycle `WAIT_CYCLES`+2.
- Misaligned request: `ack_o` and the error flag are high in cycle 1; no cycle has `mem_ce_o`=1.
- Back-to-back requests: the second is accepted in the cycle after DONE, giving one idle bubble minimum.
- `rdata_o` holds its value until the next capture; it is 0 after reset.
- `mem_*` outputs are registered or decoded from registered state only. No combinational path runs from `req_i` to the RAM.

## Configuration
- Macro: `ALIGN_EXC_EN`.
- **Defined**
  - Misaligned requests raise an error: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠00.
  - Loads raise `adel_o`; stores raise `ades_o`.
  - No RAM access is made and `rdata_o` captures 0.
- **Undefined**
  - Offending low address bits are forced: halfword `addr[0]`=0, word `addr[1:0]`=00.
  - The access proceeds normally.
  - `adel_o`/`ades_o` are tied to 0.

## Test plan
- `WAIT_CYCLES`=1, SW 0x10 data 0x12345678 → `mem_sel_o`=1111 and `mem_we_o`=1 in cycles 1–2, `ack_o` in cycle 3. Then LW 0x10 → `rdata_o`=0x12345678.
- Word at 0x10 = 0x123456F0:
  - LB 0x13 → `mem_sel_o`=0001, `rdata_o`=0xFFFFFFF0.
  - LBU 0x13 → `rdata_o`=0x000000F0.
  - LH 0x10 → `rdata_o`=0x00001234.
- SH 0x12 data 0x0000ABCD → `mem_sel_o`=0011, `mem_data_o`=0xABCDABCD. Then LW 0x10 → `rdata_o`=0x1234ABCD.
- LW 0x11:
  - With `ALIGN_EXC_EN` → `mem_ce_o` never 1; `ack_o` and `adel_o` high in cycle 1.
  - Without it → word 0x10 is read, `adel_o`=0.
- `rst` low during the second ACCESS cycle → `mem_ce_o`=0 immediately, no `ack_o`. A subsequent SB 0x20 completes normally.
- `WAIT_CYCLES`=0 with back-to-back LW/LW:
  - First `ack_o` in cycle 2; second request accepted in cycle 3, `ack_o` in cycle 5.
  - `stallreq_o`=0 in each DONE cycle.
